// File: rtl/dff_stim_sequencer.sv
// Stimulus sequencer for a gate-level enabled D flip-flop lab datapath.
// Generates a slow DUT clock and A/B vectors, then checks Y/Z against an ideal model.
module dff_stim_sequencer #(
  parameter int unsigned NUM_VEC   = 8,
  parameter int unsigned PHASE_CYC = 4,
  parameter int unsigned ERR_W     = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [2*NUM_VEC-1:0]   VECTORS,
  input  logic                   DUT_Y,
  input  logic                   DUT_Z,
  output logic                   DUT_A,
  output logic                   DUT_B,
  output logic                   DUT_CLK,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   PASS,
  output logic [ERR_W-1:0]       ERR_CNT
);

  localparam int unsigned IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int unsigned PH_W  = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_HIGH   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [2:0]       state_q,   state_d;
  logic [PH_W-1:0]  phase_q,   phase_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [1:0]       vec_q [NUM_VEC];
  logic [1:0]       vec_d [NUM_VEC];
  logic             known_q,   known_d;
  logic             y_exp_q,   y_exp_d;
  logic [ERR_W-1:0] err_q,     err_d;
  logic             dut_a_q,   dut_a_d;
  logic             dut_b_q,   dut_b_d;
  logic             dut_clk_q, dut_clk_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             pass_q,    pass_d;

  logic [1:0]       cur_vec;
  logic             y_new;
  logic             known_new;
  logic             mismatch;

  // Next-state and registered-output logic; outputs follow the current state by one clock.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    known_d   = known_q;
    y_exp_d   = y_exp_q;
    err_d     = err_q;
    dut_a_d   = dut_a_q;
    dut_b_d   = dut_b_q;
    dut_clk_d = dut_clk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    cur_vec   = vec_q[idx_q];
    y_new     = y_exp_q;
    known_new = known_q;
    mismatch  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          for (int i = 0; i < int'(NUM_VEC); i++) begin
            vec_d[i] = VECTORS[2*i +: 2];
          end
          idx_d   = '0;
          phase_d = '0;
          err_d   = '0;
          known_d = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        dut_clk_d = 1'b0;
        dut_a_d   = cur_vec[1];
        dut_b_d   = cur_vec[0];
        if (phase_q == PH_W'(PHASE_CYC - 1)) begin
          phase_d = '0;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_HIGH: begin
        dut_clk_d = 1'b1;
        if (phase_q == PH_W'(PHASE_CYC - 2)) begin
          phase_d = '0;
          state_d = S_CHECK;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_CHECK: begin
        // Model of an ideal enabled DFF; nothing is scored until the first load.
        if (cur_vec[0]) begin
          y_new     = cur_vec[1];
          known_new = 1'b1;
        end
        mismatch = known_new && ((DUT_Y != y_new) || (DUT_Z != ~y_new));
        known_d  = known_new;
        y_exp_d  = y_new;
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SETUP;
        end
      end

      S_FINISH: begin
        dut_clk_d = 1'b0;
        dut_a_d   = 1'b0;
        dut_b_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        pass_d    = (err_q == '0);
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the run immediately but keeps the partial error count.
    if (ABORT && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      dut_clk_d = 1'b0;
      dut_a_d   = 1'b0;
      dut_b_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      err_d     = err_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      for (int i = 0; i < int'(NUM_VEC); i++) begin
        vec_q[i] <= 2'b00;
      end
      known_q   <= 1'b0;
      y_exp_q   <= 1'b0;
      err_q     <= '0;
      dut_a_q   <= 1'b0;
      dut_b_q   <= 1'b0;
      dut_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      vec_q     <= vec_d;
      known_q   <= known_d;
      y_exp_q   <= y_exp_d;
      err_q     <= err_d;
      dut_a_q   <= dut_a_d;
      dut_b_q   <= dut_b_d;
      dut_clk_q <= dut_clk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign DUT_A   = dut_a_q;
  assign DUT_B   = dut_b_q;
  assign DUT_CLK = dut_clk_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;

endmodule
